// File: rtl/alu_issue_stage_pkg.sv
// Shared types and constants for the ALU issue stage (decode + 2-entry skid buffer).
// Latency: none (declarations only).
// Backpressure: n/a. Optional lui decode is enabled by ALU_ISSUE_LUI_EN.
package alu_issue_stage_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int OPRN_WIDTH = 6;
  localparam logic [OPRN_WIDTH-1:0] ILLEGAL_OPRN = 6'h00;

  // Primary opcodes (INSTR[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_MULI  = 6'h1D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes (INSTR[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_MUL = 6'h2C;

  // ALU operation codes
  localparam logic [OPRN_WIDTH-1:0] ALU_OPRN_ADD = 6'h01;
  localparam logic [OPRN_WIDTH-1:0] ALU_OPRN_SUB = 6'h02;
  localparam logic [OPRN_WIDTH-1:0] ALU_OPRN_MUL = 6'h03;
  localparam logic [OPRN_WIDTH-1:0] ALU_OPRN_SHL = 6'h04;
  localparam logic [OPRN_WIDTH-1:0] ALU_OPRN_SHR = 6'h05;
  localparam logic [OPRN_WIDTH-1:0] ALU_OPRN_AND = 6'h06;
  localparam logic [OPRN_WIDTH-1:0] ALU_OPRN_OR  = 6'h07;
  localparam logic [OPRN_WIDTH-1:0] ALU_OPRN_NOR = 6'h08;
  localparam logic [OPRN_WIDTH-1:0] ALU_OPRN_SLT = 6'h09;

  // Skid-buffer occupancy
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // One decoded ALU request
  typedef struct packed {
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [OPRN_WIDTH-1:0] oprn;
    logic                  illegal;
  } entry_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream (instr + register reads) and downstream (ALU request) handshake bundle.
// Latency: none (wiring only).
// Backpressure: valid/ready on both sides; master = environment, slave = issue stage.
interface alu_issue_stage_if;
  import alu_issue_stage_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] r1_data;
  logic [DATA_WIDTH-1:0] r2_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic [OPRN_WIDTH-1:0] oprn;
  logic                  illegal;

  modport master (
    output in_valid, instr, r1_data, r2_data, out_ready,
    input  in_ready, out_valid, op1, op2, oprn, illegal
  );

  modport slave (
    input  in_valid, instr, r1_data, r2_data, out_ready,
    output in_ready, out_valid, op1, op2, oprn, illegal
  );

endinterface

// File: rtl/alu_issue_stage_decode.sv
// Combinational MIPS-style decode: instruction + rs/rt data -> ALU operands and op-code.
// Latency: 0 cycles.
// Backpressure: none; ALU_ISSUE_LUI_EN adds lui, otherwise op 0F is illegal.
module alu_issue_stage_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic [DATA_WIDTH-1:0] r1_data,
  input  logic [DATA_WIDTH-1:0] r2_data,
  output logic [DATA_WIDTH-1:0] op1,
  output logic [DATA_WIDTH-1:0] op2,
  output logic [OPRN_WIDTH-1:0] oprn,
  output logic                  illegal
);

  logic [5:0]            opc;
  logic [5:0]            funct;
  logic [4:0]            shamt;
  logic [15:0]           imm;
  logic [DATA_WIDTH-1:0] imm_sx;
  logic [DATA_WIDTH-1:0] imm_zx;
  logic                  unused_regfields;

  assign opc    = instr[31:26];
  assign funct  = instr[5:0];
  assign shamt  = instr[10:6];
  assign imm    = instr[15:0];
  assign imm_sx = {{16{imm[15]}}, imm};
  assign imm_zx = {16'h0000, imm};
  // rs/rt select fields are consumed by the register file, not here
  assign unused_regfields = ^instr[25:16];

  // Default to the illegal encoding; each legal pattern overrides all four outputs
  always_comb begin
    op1     = '0;
    op2     = '0;
    oprn    = ILLEGAL_OPRN;
    illegal = 1'b1;
    case (opc)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_MUL, FN_AND, FN_OR, FN_NOR, FN_SLT: begin
            op1     = r1_data;
            op2     = r2_data;
            illegal = 1'b0;
            case (funct)
              FN_ADD:  oprn = ALU_OPRN_ADD;
              FN_SUB:  oprn = ALU_OPRN_SUB;
              FN_MUL:  oprn = ALU_OPRN_MUL;
              FN_AND:  oprn = ALU_OPRN_AND;
              FN_OR:   oprn = ALU_OPRN_OR;
              FN_NOR:  oprn = ALU_OPRN_NOR;
              default: oprn = ALU_OPRN_SLT;
            endcase
          end
          FN_SLL, FN_SRL: begin
            // shifts operate on rt by the encoded shift amount
            op1     = r2_data;
            op2     = {27'd0, shamt};
            oprn    = (funct == FN_SLL) ? ALU_OPRN_SHL : ALU_OPRN_SHR;
            illegal = 1'b0;
          end
          default: ;
        endcase
      end
      OPC_ADDI, OPC_LW, OPC_SW: begin
        op1 = r1_data; op2 = imm_sx; oprn = ALU_OPRN_ADD; illegal = 1'b0;
      end
      OPC_MULI: begin
        op1 = r1_data; op2 = imm_sx; oprn = ALU_OPRN_MUL; illegal = 1'b0;
      end
      OPC_ANDI: begin
        op1 = r1_data; op2 = imm_zx; oprn = ALU_OPRN_AND; illegal = 1'b0;
      end
      OPC_ORI: begin
        op1 = r1_data; op2 = imm_zx; oprn = ALU_OPRN_OR; illegal = 1'b0;
      end
      OPC_SLTI: begin
        op1 = r1_data; op2 = imm_sx; oprn = ALU_OPRN_SLT; illegal = 1'b0;
      end
      OPC_BEQ, OPC_BNE: begin
        // subtract; the ALU zero flag resolves the branch
        op1 = r1_data; op2 = r2_data; oprn = ALU_OPRN_SUB; illegal = 1'b0;
      end
`ifdef ALU_ISSUE_LUI_EN
      OPC_LUI: begin
        op1 = imm_zx; op2 = 32'd16; oprn = ALU_OPRN_SHL; illegal = 1'b0;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes each accepted instruction into a 2-entry skid buffer (macro ALU_ISSUE_LUI_EN enables lui).
// Latency: 1 cycle from in-fire to OUT_VALID when empty; full throughput when downstream ready.
// Backpressure: IN_READY is registered and drops only when both entries are full; outputs hold while stalled.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  alu_issue_stage_if.slave   ifc
);

  state_t                state;
  entry_t                out_q;
  entry_t                skid_q;
  entry_t                dec;
  logic                  out_valid_q;
  logic                  in_ready_q;
  logic                  in_fire;
  logic                  out_fire;
  logic [DATA_WIDTH-1:0] dec_op1;
  logic [DATA_WIDTH-1:0] dec_op2;
  logic [OPRN_WIDTH-1:0] dec_oprn;
  logic                  dec_illegal;

  alu_issue_stage_decode u_decode (
    .instr   (ifc.instr),
    .r1_data (ifc.r1_data),
    .r2_data (ifc.r2_data),
    .op1     (dec_op1),
    .op2     (dec_op2),
    .oprn    (dec_oprn),
    .illegal (dec_illegal)
  );

  assign dec      = '{op1: dec_op1, op2: dec_op2, oprn: dec_oprn, illegal: dec_illegal};
  assign in_fire  = ifc.in_valid & in_ready_q;
  assign out_fire = out_valid_q & ifc.out_ready;

  // Skid FSM: output register feeds the ALU, skid register absorbs one extra entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
            state       <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            out_q <= dec;
          end else if (in_fire) begin
            skid_q     <= dec;
            in_ready_q <= 1'b0;
            state      <= ST_TWO;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
            state       <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state      <= ST_ONE;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign ifc.in_ready  = in_ready_q;
  assign ifc.out_valid = out_valid_q;
  assign ifc.op1       = out_q.op1;
  assign ifc.op2       = out_q.op2;
  assign ifc.oprn      = out_q.oprn;
  assign ifc.illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table, streaming, back-pressure, illegal, reset in TWO.
// Latency: expects outputs one cycle after acceptance.
// Backpressure: exercises OUT_READY=0 with a full skid buffer; lui expectation follows ALU_ISSUE_LUI_EN.
module tb_alu_issue_stage;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  alu_issue_stage_if ifc ();

  alu_issue_stage dut (
    .clk (clk),
    .rst (rst),
    .ifc (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then stable until the next edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    ifc.in_valid = 1'b1;
    ifc.instr    = ins;
    ifc.r1_data  = a;
    ifc.r2_data  = b;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                         input logic [5:0] eo, input logic eill);
    chk({tag, ".vld"}, 32'(ifc.out_valid), 32'd1);
    chk({tag, ".op1"}, ifc.op1, e1);
    chk({tag, ".op2"}, ifc.op2, e2);
    chk({tag, ".oprn"}, 32'(ifc.oprn), 32'(eo));
    chk({tag, ".ill"}, 32'(ifc.illegal), 32'(eill));
  endtask

  // Streaming issue with OUT_READY=1: accepted now, visible after one edge
  task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [5:0] eo, input logic eill);
    drive(ins, a, b);
    step();
    chk({tag, ".rdy"}, 32'(ifc.in_ready), 32'd1);
    chk_out(tag, e1, e2, eo, eill);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.instr     = '0;
    ifc.r1_data   = '0;
    ifc.r2_data   = '0;
    ifc.out_ready = 1'b1;

    // Reset held two cycles
    step();
    step();
    rst = 1'b0;
    chk("rst.vld", 32'(ifc.out_valid), 32'd0);
    chk("rst.rdy", 32'(ifc.in_ready), 32'd1);
    chk("rst.oprn", 32'(ifc.oprn), 32'd0);
    chk("rst.op1", ifc.op1, 32'd0);
    chk("rst.ill", 32'(ifc.illegal), 32'd0);

    // Back-to-back stream covering the decode table
    issue("add",  32'h00221820, 32'd5,  32'd7,  32'd5,  32'd7,  6'h01, 1'b0);
    issue("sub",  32'h00221822, 32'd10, 32'd3,  32'd10, 32'd3,  6'h02, 1'b0);
    issue("mul",  32'h0022182C, 32'd6,  32'd7,  32'd6,  32'd7,  6'h03, 1'b0);
    issue("and",  32'h00221824, 32'hF0, 32'h3C, 32'hF0, 32'h3C, 6'h06, 1'b0);
    issue("or",   32'h00221825, 32'd1,  32'd2,  32'd1,  32'd2,  6'h07, 1'b0);
    issue("nor",  32'h00221827, 32'd4,  32'd8,  32'd4,  32'd8,  6'h08, 1'b0);
    issue("slt",  32'h0022182A, 32'd9,  32'd11, 32'd9,  32'd11, 6'h09, 1'b0);
    issue("sll",  32'h00021900, 32'd99, 32'd3,  32'd3,  32'd4,  6'h04, 1'b0);
    issue("srl",  32'h00021FC2, 32'd1,  32'h80000000, 32'h80000000, 32'd31, 6'h05, 1'b0);
    issue("addi", 32'h2022FFFF, 32'd1,  32'd2,  32'd1,  32'hFFFFFFFF, 6'h01, 1'b0);
    issue("andi", 32'h3022FFFF, 32'd1,  32'd2,  32'd1,  32'h0000FFFF, 6'h06, 1'b0);
    issue("lw",   32'h8C228000, 32'h100, 32'd2, 32'h100, 32'hFFFF8000, 6'h01, 1'b0);
    issue("sw",   32'hAC220010, 32'h200, 32'd2, 32'h200, 32'h00000010, 6'h01, 1'b0);
    issue("muli", 32'h74227FFF, 32'd3,  32'd2,  32'd3,  32'h00007FFF, 6'h03, 1'b0);
    issue("ori",  32'h34228001, 32'd3,  32'd2,  32'd3,  32'h00008001, 6'h07, 1'b0);
    issue("slti", 32'h2822FFFE, 32'd3,  32'd2,  32'd3,  32'hFFFFFFFE, 6'h09, 1'b0);
    issue("beq",  32'h10220005, 32'd8,  32'd9,  32'd8,  32'd9,  6'h02, 1'b0);
    issue("bne",  32'h14220003, 32'd8,  32'd8,  32'd8,  32'd8,  6'h02, 1'b0);
    issue("ill_op", 32'hFC221820, 32'd5, 32'd7, 32'd0,  32'd0,  6'h00, 1'b1);
    issue("ill_fn", 32'h0022183F, 32'd5, 32'd7, 32'd0,  32'd0,  6'h00, 1'b1);
    issue("post_ill", 32'h00221820, 32'd2, 32'd3, 32'd2, 32'd3, 6'h01, 1'b0);

    // Drain to EMPTY
    ifc.in_valid = 1'b0;
    step();
    chk("drain.vld", 32'(ifc.out_valid), 32'd0);

    // Back-pressure: three offered, two accepted, order preserved on release
    ifc.out_ready = 1'b0;
    drive(32'h00221820, 32'd1, 32'd2);
    step();
    chk_out("bp.a", 32'd1, 32'd2, 6'h01, 1'b0);
    chk("bp.a.rdy", 32'(ifc.in_ready), 32'd1);
    drive(32'h00221822, 32'd3, 32'd4);
    step();
    chk("bp.b.rdy", 32'(ifc.in_ready), 32'd0);
    chk_out("bp.b.hold", 32'd1, 32'd2, 6'h01, 1'b0);
    drive(32'h00221824, 32'd5, 32'd6);
    step();
    chk("bp.c.rdy", 32'(ifc.in_ready), 32'd0);
    chk_out("bp.c.hold", 32'd1, 32'd2, 6'h01, 1'b0);
    ifc.out_ready = 1'b1;
    step();
    chk_out("bp.rel.b", 32'd3, 32'd4, 6'h02, 1'b0);
    chk("bp.rel.rdy", 32'(ifc.in_ready), 32'd1);
    step();
    chk_out("bp.rel.c", 32'd5, 32'd6, 6'h06, 1'b0);
    ifc.in_valid = 1'b0;
    step();
    chk("bp.empty", 32'(ifc.out_valid), 32'd0);
    chk("bp.empty.rdy", 32'(ifc.in_ready), 32'd1);

    // Fill to TWO, then reset discards both entries
    ifc.out_ready = 1'b0;
    drive(32'h00221820, 32'd7, 32'd8);
    step();
    drive(32'h00221820, 32'd9, 32'd10);
    step();
    chk("two.rdy", 32'(ifc.in_ready), 32'd0);
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2.vld", 32'(ifc.out_valid), 32'd0);
    chk("rst2.rdy", 32'(ifc.in_ready), 32'd1);
    chk("rst2.op1", ifc.op1, 32'd0);
    ifc.out_ready = 1'b1;

    // lui: decoded only when the option is built in
`ifdef ALU_ISSUE_LUI_EN
    issue("lui", 32'h3C020001, 32'd77, 32'd5, 32'd1, 32'd16, 6'h04, 1'b0);
`else
    issue("lui", 32'h3C020001, 32'd77, 32'd5, 32'd0, 32'd0, 6'h00, 1'b1);
`endif
    ifc.in_valid = 1'b0;
    step();
    chk("end.vld", 32'(ifc.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
